// File: rtl/jesd_stream_serializer.sv
// jesd_stream_serializer: wide per-lane words in, one 32-bit beat per lane per
// cycle out toward a JESD204C TX core. Two-entry ping-pong buffer with sticky
// underrun flag and saturating underrun cycle counter.

// Per-lane beat select: picks beat `beat` out of one lane's RATIO-beat slice.
module jss_lane_mux #(
  parameter int RATIO = 4,
  parameter int LW    = 32,
  parameter int BW    = $clog2(RATIO)
) (
  input  logic [RATIO-1:0][LW-1:0] word,
  input  logic [BW-1:0]            beat,
  output logic [LW-1:0]            beat_data
);
  assign beat_data = word[beat];
endmodule

module jesd_stream_serializer #(
  parameter int JESD_LANE_NUMBER               = 2,
  parameter int JESD_CORE_CLK_SAMPLE_CLK_RATIO = 4,
  parameter int JESD204C_LANE_WIDTH            = 32,
  parameter int AXI_STREAM_IN_WIDTH            = JESD_LANE_NUMBER*JESD204C_LANE_WIDTH*JESD_CORE_CLK_SAMPLE_CLK_RATIO,
  parameter int AXI_STREAM_OUT_WIDTH           = JESD_LANE_NUMBER*JESD204C_LANE_WIDTH
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [AXI_STREAM_IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [AXI_STREAM_OUT_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            underrun,
  output logic [15:0]                     underrun_count
);
  localparam int NUM_LANES = JESD_LANE_NUMBER;
  localparam int RATIO     = JESD_CORE_CLK_SAMPLE_CLK_RATIO;
  localparam int LW        = JESD204C_LANE_WIDTH;
  localparam int WORD_W    = LW*RATIO;
  localparam int BW        = $clog2(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO-1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [1:0][AXI_STREAM_IN_WIDTH-1:0] entry;
  logic                                wr_ptr, rd_ptr;
  logic [1:0]                          count;
  logic [BW-1:0]                       beat;
  logic [0:0]                          state;
  logic                                rdy_en;   // holds s_axis_tready low through reset
  logic                                acc, pop, last_pop;
  logic [AXI_STREAM_IN_WIDTH-1:0]      rd_word;
  logic [NUM_LANES-1:0][LW-1:0]        lane_out;

  // Handshakes are derived from registered state only (no tready-to-tready path).
  assign s_axis_tready = rdy_en && (count != 2'd2);
  assign m_axis_tvalid = (count != 2'd0);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_pop      = pop && (beat == LAST_BEAT);
  assign rd_word       = entry[rd_ptr];
  assign m_axis_tdata  = lane_out;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    jss_lane_mux #(.RATIO(RATIO), .LW(LW), .BW(BW)) u_mux (
      .word      (rd_word[i*WORD_W +: WORD_W]),
      .beat      (beat),
      .beat_data (lane_out[i])
    );
  end

  // Buffer, pointers, beat counter and run state.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      entry  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      beat   <= '0;
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (acc) begin
        entry[wr_ptr] <= s_axis_tdata;
        wr_ptr        <= ~wr_ptr;
        state         <= ST_RUN;
      end
      if (pop) begin
        if (last_pop) begin
          beat   <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      count <= count + 2'(acc) - 2'(last_pop);
    end
  end

  // Underrun: the core wants data, streaming has begun, and nothing is buffered.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      underrun       <= 1'b0;
      underrun_count <= 16'h0000;
    end else if (state == ST_RUN && count == 2'd0 && m_axis_tready) begin
      underrun <= 1'b1;
      if (underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'h0001;
    end
  end
endmodule

// File: tb/tb_jesd_stream_serializer.sv
// Directed bench for jesd_stream_serializer (LANES=2, RATIO=4).
module tb_jesd_stream_serializer;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         urun;
  logic [15:0]  urun_cnt;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  jesd_stream_serializer dut (
    .axis_aclk      (clk),
    .axis_areset    (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .underrun       (urun),
    .underrun_count (urun_cnt)
  );

  // Lane l beat b carries (l ? 0x10000000 : 0) | (base + b).
  function automatic logic [255:0] mk_word(input logic [31:0] base);
    logic [255:0] w;
    w = '0;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 4; b++)
        w[l*128 + b*32 +: 32] = (l == 1 ? 32'h1000_0000 : 32'h0) | (base + 32'(b));
    return w;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [31:0] base, input int b);
    return {32'h1000_0000 | (base + 32'(b)), base + 32'(b)};
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    step; step;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    total++; if (m_tdata !== 64'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    total++; if (urun !== 1'b0 || urun_cnt !== 16'h0) begin bad++; $display("FAIL reset_underrun got=%b/%h exp=0/0", urun, urun_cnt); end
    rst = 1'b0;
    step;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL post_reset_tready got=%b exp=1", s_tready); end
    total++; if (urun !== 1'b0) begin bad++; $display("FAIL idle_no_underrun got=%b exp=0", urun); end
  endtask

  task automatic test_single;
    do_reset;
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = mk_word(32'h0);
    step;
    s_tvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(32'h0, b)) begin
        bad++; $display("FAIL single_beat%0d got=%b/%h exp=1/%h", b, m_tvalid, m_tdata, exp_beat(32'h0, b));
      end
      step;
    end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", m_tvalid); end
    total++; if (urun_cnt !== 16'h0) begin bad++; $display("FAIL single_cnt_before got=%h exp=0", urun_cnt); end
    step; step; step;
    total++; if (urun !== 1'b1 || urun_cnt !== 16'd3) begin bad++; $display("FAIL single_underrun got=%b/%h exp=1/3", urun, urun_cnt); end
  endtask

  task automatic test_backpressure;
    do_reset;
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = mk_word(32'h100);
    step;
    s_tdata = mk_word(32'h200);
    step;
    s_tdata = mk_word(32'h300);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL bp_full_tready got=%b exp=0", s_tready); end
    step; step; step;
    total++; if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(32'h100, 0)) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", m_tvalid, m_tdata, exp_beat(32'h100, 0)); end
    total++; if (urun !== 1'b0 || s_tready !== 1'b0) begin bad++; $display("FAIL bp_flags got=%b/%b exp=0/0", urun, s_tready); end
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(k < 4 ? 32'h100 : 32'h200, k % 4)) begin
        bad++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", k, m_tvalid, m_tdata, exp_beat(k < 4 ? 32'h100 : 32'h200, k % 4));
      end
      step;
    end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_stream;
    int  sent, got, gaps, early_urun, cyc;
    logic will_acc;
    do_reset;
    sent = 0; got = 0; gaps = 0; early_urun = 0; cyc = 0;
    m_tready = 1'b1;
    while (got < 400 && cyc < 1000) begin
      if (m_tvalid) begin
        total++;
        if (m_tdata !== exp_beat(32'h1000 + 32'(got / 4) * 16, got % 4)) begin
          bad++; $display("FAIL stream_beat%0d got=%h exp=%h", got, m_tdata, exp_beat(32'h1000 + 32'(got / 4) * 16, got % 4));
        end
        got++;
      end else if (got > 0) gaps++;
      if (urun) early_urun++;
      s_tvalid = (sent < 100);
      s_tdata  = mk_word(32'h1000 + 32'(sent) * 16);
      will_acc = s_tvalid && s_tready;
      step;
      if (will_acc) sent++;
      cyc++;
    end
    s_tvalid = 1'b0;
    total++; if (got !== 400) begin bad++; $display("FAIL stream_count got=%0d exp=400", got); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    total++; if (early_urun !== 0) begin bad++; $display("FAIL stream_underrun got=%0d exp=0", early_urun); end
  endtask

  task automatic test_toggle;
    int  sent, got, cyc;
    logic will_acc, rdy;
    do_reset;
    sent = 0; got = 0; cyc = 0;
    while (got < 200 && cyc < 3000) begin
      if (m_tvalid) begin
        total++;
        if (m_tdata !== exp_beat(32'h8000 + 32'(got / 4) * 16, got % 4)) begin
          bad++; $display("FAIL toggle_beat%0d got=%h exp=%h", got, m_tdata, exp_beat(32'h8000 + 32'(got / 4) * 16, got % 4));
        end
      end
      rdy      = 1'($urandom_range(0, 1));
      m_tready = rdy;
      s_tvalid = (sent < 50);
      s_tdata  = mk_word(32'h8000 + 32'(sent) * 16);
      will_acc = s_tvalid && s_tready;
      if (m_tvalid && rdy) got++;
      step;
      if (will_acc) sent++;
      cyc++;
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    total++; if (got !== 200) begin bad++; $display("FAIL toggle_count got=%0d exp=200", got); end
    step;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL toggle_extra got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_saturation;
    do_reset;
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = mk_word(32'h40);
    step;
    s_tvalid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    total++; if (urun !== 1'b1 || urun_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_count got=%b/%h exp=1/ffff", urun, urun_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = mk_word(32'h20);
    step;
    s_tvalid = 1'b0;
    repeat (8) step;
    s_tvalid = 1'b1; s_tdata = mk_word(32'h500);
    step;
    s_tvalid = 1'b0;
    step; step;
    total++; if (m_tdata !== exp_beat(32'h500, 2) || urun !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h/%b exp=%h/1", m_tdata, urun, exp_beat(32'h500, 2)); end
    rst = 1'b1;
    step;
    total++; if (m_tvalid !== 1'b0 || urun !== 1'b0 || urun_cnt !== 16'h0) begin bad++; $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", m_tvalid, urun, urun_cnt); end
    rst = 1'b0;
    step;
    s_tvalid = 1'b1; s_tdata = mk_word(32'h600);
    step;
    s_tvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(32'h600, b)) begin
        bad++; $display("FAIL mid_new_beat%0d got=%b/%h exp=1/%h", b, m_tvalid, m_tdata, exp_beat(32'h600, b));
      end
      step;
    end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", m_tvalid); end
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_stream;
    test_toggle;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
